// File: rtl/sh_rl_param.sv
// Multi-mode shift unit: loads a narrow operand on an init_sh rising edge, then
// shifts it one bit per clock (LSL/LSR/ASR/ROR) with busy and a done pulse.
module sh_rl_param #(
  parameter int IN_W  = 3,
  parameter int OUT_W = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  portA,
  input  logic             init_sh,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] amount,
  output logic [OUT_W-1:0] sal_sh,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [1:0] M_LSL = 2'b00;
  localparam logic [1:0] M_ASR = 2'b10;
  localparam logic [1:0] M_ROR = 2'b11;
  localparam logic [CNT_W-1:0] CNT_CLAMP = CNT_W'(OUT_W);

  state_t           state_reg, state_next;
  logic [OUT_W-1:0] sal_reg, sal_next;
  logic [1:0]       mode_reg, mode_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             busy_reg, busy_next;
  logic             init_d_reg;

  logic             start_edge;
  logic             fill_msb;
  logic [OUT_W-1:0] load_val;
  logic [OUT_W-1:0] shl_val;
  logic [OUT_W-1:0] shr_val;
  logic [CNT_W-1:0] load_cnt;

  assign start_edge = init_sh & ~init_d_reg;

  // Operand extension: sign-extend only for arithmetic right shifts.
  genvar gi;
  generate
    for (gi = 0; gi < OUT_W; gi++) begin : g_ext
      if (gi < IN_W) begin : g_op
        assign load_val[gi] = portA[gi];
      end else begin : g_sx
        assign load_val[gi] = (mode == M_ASR) & portA[IN_W-1];
      end
    end
  endgenerate

  generate
    for (gi = 0; gi < OUT_W; gi++) begin : g_shl
      if (gi == 0) begin : g_lsb
        assign shl_val[gi] = 1'b0;
      end else begin : g_mid
        assign shl_val[gi] = sal_reg[gi-1];
      end
    end
  endgenerate

  generate
    for (gi = 0; gi < OUT_W; gi++) begin : g_shr
      if (gi == OUT_W - 1) begin : g_msb
        assign shr_val[gi] = fill_msb;
      end else begin : g_mid
        assign shr_val[gi] = sal_reg[gi+1];
      end
    end
  endgenerate

  // Bit entering at the MSB on right shifts depends on the captured mode.
  always_comb begin
    fill_msb = 1'b0;
    case (mode_reg)
      M_ASR:   fill_msb = sal_reg[OUT_W-1];
      M_ROR:   fill_msb = sal_reg[0];
      default: fill_msb = 1'b0;
    endcase
  end

  // Rotations keep the raw amount; the other modes saturate at the register width.
  always_comb begin
    load_cnt = amount;
    if (mode != M_ROR && amount > CNT_CLAMP) begin
      load_cnt = CNT_CLAMP;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= ST_IDLE;
      sal_reg    <= '0;
      mode_reg   <= '0;
      cnt_reg    <= '0;
      busy_reg   <= 1'b0;
      init_d_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      sal_reg    <= sal_next;
      mode_reg   <= mode_next;
      cnt_reg    <= cnt_next;
      busy_reg   <= busy_next;
      init_d_reg <= init_sh;
    end
  end

  always_comb begin
    state_next = state_reg;
    sal_next   = sal_reg;
    mode_next  = mode_reg;
    cnt_next   = cnt_reg;
    busy_next  = busy_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start_edge) begin
          sal_next  = load_val;
          mode_next = mode;
          cnt_next  = load_cnt;
          if (load_cnt != '0) begin
            state_next = ST_SHIFT;
            busy_next  = 1'b1;
          end else begin
            state_next = ST_DONE;
            busy_next  = 1'b0;
          end
        end
      end
      ST_SHIFT: begin
        sal_next = (mode_reg == M_LSL) ? shl_val : shr_val;
        cnt_next = cnt_reg - 1'b1;
        if (cnt_reg <= CNT_W'(1)) begin
          state_next = ST_DONE;
          busy_next  = 1'b0;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
        busy_next  = 1'b0;
      end
    endcase
  end

  always_comb begin
    sal_sh = sal_reg;
    busy   = busy_reg;
    done   = (state_reg == ST_DONE);
  end

endmodule

// File: tb/tb_sh_rl_param.sv
// Randomized bench for sh_rl_param: each operation's cycle-by-cycle sal_sh,
// busy and done are predicted from an arithmetic model of the shift rules.
module tb_sh_rl_param;

  localparam int IN_W  = 3;
  localparam int OUT_W = 4;
  localparam int CNT_W = 3;
  localparam int MASK  = (1 << OUT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [IN_W-1:0]  portA = '0;
  logic             init_sh = 1'b0;
  logic [1:0]       mode = '0;
  logic [CNT_W-1:0] amount = '0;
  logic [OUT_W-1:0] sal_sh;
  logic             busy;
  logic             done;

  int n_checks = 0;
  int n_pass   = 0;

  sh_rl_param #(.IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .portA(portA), .init_sh(init_sh), .mode(mode),
    .amount(amount), .sal_sh(sal_sh), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic check_out(input string tag, input int e_sal, input int e_busy, input int e_done);
    check({tag, ".sal"},  int'(sal_sh), e_sal);
    check({tag, ".busy"}, int'(busy),   e_busy);
    check({tag, ".done"}, int'(done),   e_done);
  endtask

  function automatic int eff_count(input int m, input int amt);
    if (m == 3) return amt;
    return (amt > OUT_W) ? OUT_W : amt;
  endfunction

  function automatic int extend(input int a, input int m);
    if (m == 2 && ((a >> (IN_W - 1)) & 1) == 1)
      return (a | (MASK & ~((1 << IN_W) - 1))) & MASK;
    return a & MASK;
  endfunction

  // Value after k single-bit shifts, computed in closed form.
  function automatic int after_k(input int v, input int m, input int k);
    int s;
    int r;
    case (m)
      0: return (v << k) & MASK;
      1: return v >> k;
      2: begin
        s = (v >= (1 << (OUT_W - 1))) ? v - (1 << OUT_W) : v;
        return (s >>> k) & MASK;
      end
      default: begin
        r = k % OUT_W;
        if (r == 0) return v;
        return ((v >> r) | (v << (OUT_W - r))) & MASK;
      end
    endcase
  endfunction

  // Follows one operation whose start edge is the next rising clock edge.
  task automatic follow_op(input int a, input int m, input int amt, input bit hold, input bit retrig);
    int n;
    int v0;
    int fin;
    n   = eff_count(m, amt);
    v0  = extend(a, m);
    fin = after_k(v0, m, n);
    @(posedge clk);
    #1;
    if (!hold) init_sh = 1'b0;
    portA  = IN_W'($urandom);
    mode   = 2'($urandom);
    amount = CNT_W'($urandom);
    @(negedge clk);
    check_out("load", v0, (n > 0) ? 1 : 0, (n == 0) ? 1 : 0);
    for (int k = 1; k <= n; k++) begin
      @(posedge clk);
      #1;
      if (retrig && k == 1) init_sh = 1'b1;
      if (retrig && k == 2) init_sh = 1'b0;
      @(negedge clk);
      check_out($sformatf("shift%0d", k), after_k(v0, m, k), (k < n) ? 1 : 0, (k == n) ? 1 : 0);
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    check_out("idle", fin, 0, 0);
    $display("op portA=%0d mode=%0d amount=%0d eff=%0d -> sal_sh=%0d (model %0d)",
             a, m, amt, n, sal_sh, fin);
  endtask

  task automatic run_op(input int a, input int m, input int amt, input bit hold, input bit retrig);
    @(posedge clk);
    #1;
    portA   = IN_W'(a);
    mode    = 2'(m);
    amount  = CNT_W'(amt);
    init_sh = 1'b1;
    follow_op(a, m, amt, hold, retrig);
  endtask

  initial begin
    int a;
    int m;
    int amt;
    #1 rst = 1'b0;
    #2 check_out("rst0", 0, 0, 0);
    #5 check_out("rst_edge", 0, 0, 0);
    #4 rst = 1'b1;

    run_op(5, 0, 1, 0, 0);
    run_op(5, 1, 2, 0, 0);
    run_op(5, 2, 2, 0, 0);
    run_op(5, 3, 1, 0, 0);
    run_op(5, 3, 5, 0, 0);
    run_op(5, 0, 7, 0, 0);
    run_op(3, 0, 0, 0, 0);

    // init_sh held high: exactly one operation, no retrigger afterwards
    run_op(5, 0, 2, 1, 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_out("held", after_k(5, 0, 2), 0, 0);
    end
    #1 init_sh = 1'b0;

    // Second rising edge during SHIFT is lost
    run_op(6, 1, 4, 0, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_out("retrig_idle", after_k(6, 1, 4), 0, 0);
    end

    // Reset mid-shift, then init_sh already high at reset release
    @(posedge clk);
    #1;
    portA = 3'd6; mode = 2'd1; amount = 3'd4; init_sh = 1'b1;
    @(posedge clk);
    #1 init_sh = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b0;
    #1 check_out("midrst", 0, 0, 0);
    portA = 3'd3; mode = 2'd2; amount = 3'd1; init_sh = 1'b1;
    @(negedge clk);
    check_out("midrst_hold", 0, 0, 0);
    #1 rst = 1'b1;
    follow_op(3, 2, 1, 0, 0);

    for (int i = 0; i < 40; i++) begin
      a   = int'($urandom_range(0, (1 << IN_W) - 1));
      m   = int'($urandom_range(0, 3));
      amt = int'($urandom_range(0, (1 << CNT_W) - 1));
      run_op(a, m, amt, 0, (eff_count(m, amt) >= 3 && (i % 4 == 0)) ? 1'b1 : 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
